// File: rtl/wallie_top.sv
// Wallie power I2C bridge: forwards host SCL onto the power bus and bridges SDA both ways
// through an ownership arbiter. Optional 3-sample majority input filter: WALLIE_I2C_GLITCH_FILTER_EN.
module wallie_top #(
    parameter int RELEASE_HOLD = 4,
    parameter int LED_HOLD     = 2_000_000
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic io_scl,
    inout  wire  io_sda,
    output wire  io_power_scl,
    inout  wire  io_power_sda,
    output logic led1,
    output logic gpio_21
);

    localparam int NUM_CH       = 3;
    localparam int CH_SCL       = 0;
    localparam int CH_HOST_SDA  = 1;
    localparam int CH_POWER_SDA = 2;
    localparam int HOLD_W       = (RELEASE_HOLD > 1) ? $clog2(RELEASE_HOLD) : 1;
    localparam int LED_W        = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((RELEASE_HOLD > 0) ? RELEASE_HOLD - 1 : 0);
    localparam logic [LED_W-1:0]  LED_INIT  = LED_W'(LED_HOLD);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOST   = 3'd1,
        ST_POWER  = 3'd2,
        ST_HOLD_H = 3'd3,
        ST_HOLD_P = 3'd4
    } state_t;

    logic [NUM_CH-1:0] pin_in;
    logic [NUM_CH-1:0] clean_in;

    assign pin_in = {io_power_sda, io_sda, io_scl};

    // Per-input conditioning: 2-FF synchroniser (reset to the idle-high level), optional filter.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic sync1_q, sync1_d;
            logic sync2_q, sync2_d;

            always_comb begin
                sync1_d = pin_in[gi];
                sync2_d = sync1_q;
            end

            always_ff @(posedge clk_100mhz) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                end
            end

`ifdef WALLIE_I2C_GLITCH_FILTER_EN
            logic hist1_q, hist1_d;
            logic hist2_q, hist2_d;
            logic filt_q, filt_d;

            always_comb begin
                hist1_d = sync2_q;
                hist2_d = hist1_q;
                filt_d  = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
            end

            always_ff @(posedge clk_100mhz) begin
                if (rst) begin
                    hist1_q <= 1'b1;
                    hist2_q <= 1'b1;
                    filt_q  <= 1'b1;
                end else begin
                    hist1_q <= hist1_d;
                    hist2_q <= hist2_d;
                    filt_q  <= filt_d;
                end
            end

            assign clean_in[gi] = filt_q;
`else
            assign clean_in[gi] = sync2_q;
`endif
        end
    endgenerate

    logic scl_in;
    logic host_sda_in;
    logic power_sda_in;

    assign scl_in       = clean_in[CH_SCL];
    assign host_sda_in  = clean_in[CH_HOST_SDA];
    assign power_sda_in = clean_in[CH_POWER_SDA];

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // The owned side's own input is never looked at, so our drive cannot latch back onto us.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!host_sda_in) begin
                    state_d = ST_HOST;
                end else if (!power_sda_in) begin
                    state_d = ST_POWER;
                end
            end
            ST_HOST: begin
                if (host_sda_in) begin
                    state_d    = ST_HOLD_H;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            ST_POWER: begin
                if (power_sda_in) begin
                    state_d    = ST_HOLD_P;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            ST_HOLD_H, ST_HOLD_P: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    logic             drive_host_q, drive_host_d;
    logic             drive_power_q, drive_power_d;
    logic             scl_drive_q, scl_drive_d;
    logic             scl_prev_q, scl_prev_d;
    logic             gpio_q, gpio_d;
    logic [LED_W-1:0] led_cnt_q, led_cnt_d;
    logic             led_q, led_d;
    logic             activity;

    always_comb begin
        drive_power_d = (state_d == ST_HOST);
        drive_host_d  = (state_d == ST_POWER);
        gpio_d        = (state_d != ST_IDLE);
        scl_drive_d   = ~scl_in;
        scl_prev_d    = scl_in;
        activity      = (state_d != state_q) || (scl_prev_q && !scl_in);

        led_cnt_d = led_cnt_q;
        if (activity) begin
            led_cnt_d = LED_INIT;
        end else if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - LED_W'(1);
        end
        led_d = (led_cnt_d != '0);
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            drive_host_q  <= 1'b0;
            drive_power_q <= 1'b0;
            scl_drive_q   <= 1'b0;
            scl_prev_q    <= 1'b1;
            gpio_q        <= 1'b0;
            led_cnt_q     <= '0;
            led_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            drive_host_q  <= drive_host_d;
            drive_power_q <= drive_power_d;
            scl_drive_q   <= scl_drive_d;
            scl_prev_q    <= scl_prev_d;
            gpio_q        <= gpio_d;
            led_cnt_q     <= led_cnt_d;
            led_q         <= led_d;
        end
    end

    // Open-drain pads: a bridge output only ever pulls low or floats.
    assign io_sda       = drive_host_q  ? 1'b0 : 1'bz;
    assign io_power_sda = drive_power_q ? 1'b0 : 1'bz;
    assign io_power_scl = scl_drive_q   ? 1'b0 : 1'bz;
    assign gpio_21      = gpio_q;
    assign led1         = led_q;

endmodule

// File: tb/tb_wallie_top.sv
// Directed bench for wallie_top: reset, SCL forwarding with LED timing, SDA bridging both
// ways, simultaneous pull, reset during ownership and short-pulse handling.
module tb_wallie_top;

    localparam int RELEASE_HOLD = 4;
    localparam int LED_HOLD     = 20;
    localparam int SCL_LEN      = 24;
`ifdef WALLIE_I2C_GLITCH_FILTER_EN
    localparam int LAT       = 5;
    localparam int MIN_FWD_W = 2;
`else
    localparam int LAT       = 3;
    localparam int MIN_FWD_W = 1;
`endif

    logic clk_100mhz = 1'b0;
    logic rst;
    logic io_scl;
    logic host_pull;
    logic power_pull;
    wire  io_sda;
    wire  io_power_sda;
    wire  io_power_scl;
    wire  led1;
    wire  gpio_21;

    int vectors     = 0;
    int miscompares = 0;

    logic [SCL_LEN-1:0] scl_pat;
    logic               exp_scl;
    logic               prev_scl;
    int                 led_left;

    assign io_sda       = host_pull  ? 1'b0 : 1'bz;
    assign io_power_sda = power_pull ? 1'b0 : 1'bz;
    pullup (io_sda);
    pullup (io_power_sda);
    pullup (io_power_scl);

    wallie_top #(
        .RELEASE_HOLD (RELEASE_HOLD),
        .LED_HOLD     (LED_HOLD)
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .rst          (rst),
        .io_scl       (io_scl),
        .io_sda       (io_sda),
        .io_power_scl (io_power_scl),
        .io_power_sda (io_power_sda),
        .led1         (led1),
        .gpio_21      (gpio_21)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic step(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Low pulse of 'width' cycles on one SDA side; checks the far side, the pulled pin and gpio_21.
    task automatic sda_pulse(input bit from_host, input int width, input string tag);
        logic fwd_ok;
        logic fwd;
        logic own;
        int   last;
        fwd_ok = (width >= MIN_FWD_W);
        last   = width + LAT + RELEASE_HOLD + 2;
        for (int e = 0; e <= last; e++) begin
            fwd = fwd_ok && (e >= LAT) && (e < width + LAT);
            own = fwd_ok && (e >= LAT) && (e < width + LAT + RELEASE_HOLD);
            if (from_host) begin
                check($sformatf("%s_power_sda@%0d", tag, e), io_power_sda, ~fwd);
                check($sformatf("%s_host_sda@%0d", tag, e), io_sda, ~host_pull);
                host_pull = (e < width);
            end else begin
                check($sformatf("%s_host_sda@%0d", tag, e), io_sda, ~fwd);
                check($sformatf("%s_power_sda@%0d", tag, e), io_power_sda, ~power_pull);
                power_pull = (e < width);
            end
            check($sformatf("%s_gpio@%0d", tag, e), gpio_21, own);
            step(1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        io_scl     = 1'b1;
        host_pull  = 1'b0;
        power_pull = 1'b0;
        step(2);
        check("rst_io_sda", io_sda, 1'b1);
        check("rst_io_power_sda", io_power_sda, 1'b1);
        check("rst_io_power_scl", io_power_scl, 1'b1);
        check("rst_led1", led1, 1'b0);
        check("rst_gpio_21", gpio_21, 1'b0);
        rst = 1'b0;
        step(3);

        // SCL forwarding with a reference LED countdown model.
`ifdef WALLIE_I2C_GLITCH_FILTER_EN
        scl_pat = 24'b1111_0000_1111_1111_0000_1111;
`else
        scl_pat = 24'b1111_1010_1100_0101_0011_0110;
`endif
        prev_scl = 1'b1;
        led_left = 0;
        for (int e = 0; e < SCL_LEN + LAT + LED_HOLD + 2; e++) begin
            exp_scl = (e >= LAT && e - LAT < SCL_LEN) ? scl_pat[e - LAT] : 1'b1;
            if (!exp_scl && prev_scl) led_left = LED_HOLD;
            check($sformatf("scl@%0d", e), io_power_scl, exp_scl);
            check($sformatf("led@%0d", e), led1, (led_left != 0));
            if (led_left > 0) led_left--;
            prev_scl = exp_scl;
            io_scl   = (e < SCL_LEN) ? scl_pat[e] : 1'b1;
            step(1);
        end

        sda_pulse(1'b1, 4, "host");
        sda_pulse(1'b0, 9, "power");
        sda_pulse(1'b1, 1, "short");

        // Both sides low together: host wins, power takes over after the hold.
        host_pull  = 1'b1;
        power_pull = 1'b1;
        step(LAT);
        check("simul_gpio", gpio_21, 1'b1);
        check("simul_power_sda", io_power_sda, 1'b0);
        host_pull = 1'b0;
        for (int r = 1; r <= LAT + RELEASE_HOLD + 2; r++) begin
            step(1);
            check($sformatf("simul_host_sda@%0d", r), io_sda, (r >= LAT + RELEASE_HOLD + 1) ? 1'b0 : 1'b1);
            check($sformatf("simul_gpio@%0d", r), gpio_21, (r == LAT + RELEASE_HOLD) ? 1'b0 : 1'b1);
        end
        power_pull = 1'b0;
        for (int r = 1; r <= LAT + RELEASE_HOLD + 2; r++) begin
            step(1);
            check($sformatf("simul_rel_host_sda@%0d", r), io_sda, (r >= LAT) ? 1'b1 : 1'b0);
            check($sformatf("simul_rel_power_sda@%0d", r), io_power_sda, 1'b1);
            check($sformatf("simul_rel_gpio@%0d", r), gpio_21, (r < LAT + RELEASE_HOLD) ? 1'b1 : 1'b0);
        end

        // Reset while the host owns SDA.
        host_pull = 1'b1;
        step(LAT);
        check("own_power_sda", io_power_sda, 1'b0);
        check("own_gpio", gpio_21, 1'b1);
        check("own_led1", led1, 1'b1);
        rst = 1'b1;
        step(1);
        check("midrst_power_sda", io_power_sda, 1'b1);
        check("midrst_gpio", gpio_21, 1'b0);
        check("midrst_led1", led1, 1'b0);
        check("midrst_power_scl", io_power_scl, 1'b1);
        rst       = 1'b0;
        host_pull = 1'b0;
        step(LAT + RELEASE_HOLD + 2);
        check("post_rst_gpio", gpio_21, 1'b0);
        check("post_rst_power_sda", io_power_sda, 1'b1);
        check("post_rst_host_sda", io_sda, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wallie_top.md
# wallie_top

FPGA top level for the Wallie power I2C bridge. It repeats a host I2C bus (io_scl/io_sda) onto a downstream power-board I2C bus (io_power_scl/io_power_sda). SCL is forwarded one way, host to power. SDA is bridged in both directions, with ownership arbitration so that the bridge never latches its own drive back onto itself. Status goes to an LED and a debug GPIO.

## Interface
- RELEASE_HOLD, 4: clock cycles the non-owning side stays masked after the owner releases SDA.
- LED_HOLD, 2_000_000: cycles led1 stays lit after the last activity (20 ms at 100 MHz).
- clk_100mhz  input  1  system clock, 100 MHz.
- rst  input  1  reset; one clock, synchronous, active-high.
- io_scl  input  1  host SCL.
- io_sda  inout  1  host SDA, open-drain (drives 0 or Z only).
- io_power_scl  output  1  power-bus SCL, open-drain (0 or Z).
- io_power_sda  inout  1  power-bus SDA, open-drain (0 or Z).
- led1  output  1  activity indicator, active-high.
- gpio_21  output  1  debug; high while either side owns SDA.

## Operation
- **Input synchronisers:** io_scl, io_sda and io_power_sda each pass through a 2-FF synchroniser. A Z or pulled-up line reads as 1.
- **SCL forwarding:** io_power_scl is driven 0 when synced SCL = 0, else Z. It is registered.
- **SDA arbiter FSM** (registered):
  - IDLE:
    - synced host SDA = 0 → HOST (host wins when both sides are low in the same cycle).
    - else synced power SDA = 0 → POWER.
  - HOST: drive io_power_sda = 0, ignore synced power SDA. When synced host SDA = 1, release the drive → HOLD_H.
  - POWER: drive io_sda = 0, ignore synced host SDA. When synced power SDA = 1, release → HOLD_P.
  - HOLD_H / HOLD_P: drive nothing. Count RELEASE_HOLD cycles, then go to IDLE. This masks pull-up rise time and synchroniser delay on the side the bridge was driving.
  - If the formerly driven side is still low after the hold, another device holds it. IDLE then grants that side normally.
- A side drives only 0 or Z, never 1.
- **led1:** 1 for LED_HOLD cycles after any FSM transition or SCL falling edge. Each new event reloads the counter. The counter saturates at 0.
- **gpio_21:** 1 in HOST, POWER, HOLD_H and HOLD_P; 0 in IDLE.
- **Reset:**
  - Outputs: io_sda = Z, io_power_sda = Z, io_power_scl = Z, led1 = 0, gpio_21 = 0.
  - State: FSM = IDLE, synchronisers = 1, counters = 0.
  - Reset mid-ownership releases every drive on the next edge.

## Timing
- All outputs change only on the rising edge of clk_100mhz.
- **Latency** (input edge to output drive change): 3 cycles = 2 synchroniser stages + 1 output/FSM register (30 ns). SCL to io_power_scl uses the same 3 cycles.
- **Release turnaround:** the owner's release is seen 2 cycles after the pin rises. The drive is removed on the next edge. IDLE is reached RELEASE_HOLD cycles later.
- **Minimum SCL/SDA pulse width** that must be forwarded faithfully: 4 cycles (40 ns), far below I2C fast-mode periods.
- With the filter compiled in (see Configuration), every input-path latency grows by 2 cycles.

## Configuration
- Macro: WALLIE_I2C_GLITCH_FILTER_EN.
- **Defined:** a 3-sample majority filter follows each synchroniser on io_scl, io_sda and io_power_sda. Single-cycle glitches are rejected and latency becomes 5 cycles.
- **Undefined:** no filter. 3-cycle latency; any pulse of 1 cycle or longer after synchronisation propagates.

## Test plan
- **Host SDA bridge:** rst 2 cycles, then hold io_sda low 40 ns → io_power_sda = 0 within 3 cycles, gpio_21 = 1. Release → io_power_sda = Z within 3 cycles; gpio_21 = 0 after RELEASE_HOLD more cycles.
- **Power SDA bridge:** drive io_power_sda low 90 ns, host idle → io_sda = 0 within 3 cycles. Release → io_sda = Z, FSM returns to IDLE, no latch-up (io_power_sda reads 1).
- **SCL forwarding:** toggle io_scl at a 10 ns half-period → io_power_scl follows as 0/Z delayed by 3 cycles. led1 = 1 after the first falling edge.
- **Simultaneous pull:** both SDAs low in the same cycle → HOST owns, io_power_sda driven 0, io_sda undriven by the bridge. When the host releases while power is still low → after hold, POWER owns and io_sda = 0.
- **Reset mid-ownership:** assert rst while in HOST → next edge io_power_sda = Z, gpio_21 = 0, led1 = 0.
- **Glitch filter** (with WALLIE_I2C_GLITCH_FILTER_EN): 1-cycle low pulse on io_sda → io_power_sda stays Z. A 4-cycle pulse is forwarded with 5-cycle latency.
